mem_line_arbiter: RTL and testbench

//  Two-port line-transfer controller that shares the single-port, 1-cycle-read-latency

---
 rtl/mem_line_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_line_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_arbiter.sv
// Round-robin line-transfer controller that shares one single-port, 1-cycle-latency
// memory between two cache requesters. Bursts move one word per cycle. LINE_WORDS_LOG must be >= 1.
module mem_line_arbiter #(
   parameter int ADDR_LEN       = 11,
   parameter int LINE_WORDS_LOG = 3,
   parameter int WAIT_CYCLES    = 0
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 i_r0_req,
   input  logic                                 i_r0_we,
   input  logic [ADDR_LEN-LINE_WORDS_LOG-1:0]   i_r0_addr,
   input  logic [32*(1<<LINE_WORDS_LOG)-1:0]    i_r0_wdata,
   output logic [32*(1<<LINE_WORDS_LOG)-1:0]    o_r0_rdata,
   output logic                                 o_r0_done,
   input  logic                                 i_r1_req,
   input  logic                                 i_r1_we,
   input  logic [ADDR_LEN-LINE_WORDS_LOG-1:0]   i_r1_addr,
   input  logic [32*(1<<LINE_WORDS_LOG)-1:0]    i_r1_wdata,
   output logic [32*(1<<LINE_WORDS_LOG)-1:0]    o_r1_rdata,
   output logic                                 o_r1_done,
   output logic [ADDR_LEN-1:0]                  o_mem_addr,
   output logic                                 o_mem_wr_req,
   output logic [31:0]                          o_mem_wr_data,
   input  logic [31:0]                          i_mem_rd_data
);

   localparam int N      = 1 << LINE_WORDS_LOG;
   localparam int LINE_W = ADDR_LEN - LINE_WORDS_LOG;
   localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam bit HAS_WAIT = (WAIT_CYCLES > 0);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
   localparam logic [LINE_WORDS_LOG-1:0] K_LAST = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_RD,
      S_RD_LAST,
      S_WR,
      S_DONE
   } state_t;

   state_t                    r_state;
   state_t                    w_next;
   logic [LINE_WORDS_LOG-1:0] r_k;
   logic [WAIT_W-1:0]         r_wcnt;
   logic                      r_gnt;
   logic                      r_last_gnt;
   logic                      r_we;
   logic [LINE_W-1:0]         r_line;
   logic [N-1:0][31:0]        r_wdata;
   logic [N-2:0][31:0]        r_buf;
   logic [N-1:0][31:0]        r_rdata0;
   logic [N-1:0][31:0]        r_rdata1;

   logic                      w_any;
   logic                      w_both;
   logic                      w_pick;
   logic                      w_pick_we;
   logic [LINE_W-1:0]         w_pick_line;
   logic [N-1:0][31:0]        w_pick_wdata;
   logic [N-1:0][31:0]        w_line_in;
   logic [ADDR_LEN-1:0]       w_mem_addr;
   logic                      w_mem_wr_req;
   logic [31:0]               w_mem_wr_data;
   logic                      w_done0;
   logic                      w_done1;

   // On a tie the requester that did not win the previous tie is chosen.
   assign w_any        = i_r0_req | i_r1_req;
   assign w_both       = i_r0_req & i_r1_req;
   assign w_pick       = w_both ? ~r_last_gnt : i_r1_req;
   assign w_pick_we    = w_pick ? i_r1_we : i_r0_we;
   assign w_pick_line  = w_pick ? i_r1_addr : i_r0_addr;
   assign w_pick_wdata = w_pick ? i_r1_wdata : i_r0_wdata;
   assign w_line_in    = {i_mem_rd_data, r_buf};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next        = r_state;
      w_mem_addr    = '0;
      w_mem_wr_req  = 1'b0;
      w_mem_wr_data = '0;
      w_done0       = 1'b0;
      w_done1       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               if (HAS_WAIT) w_next = S_WAIT;
               else          w_next = w_pick_we ? S_WR : S_RD;
            end
         end
         S_WAIT: begin
            if (r_wcnt == WAIT_LAST) w_next = r_we ? S_WR : S_RD;
         end
         S_RD: begin
            w_mem_addr = {r_line, r_k};
            if (r_k == K_LAST) w_next = S_RD_LAST;
         end
         S_RD_LAST: begin
            w_next = S_DONE;
         end
         S_WR: begin
            w_mem_addr    = {r_line, r_k};
            w_mem_wr_req  = 1'b1;
            w_mem_wr_data = r_wdata[r_k];
            if (r_k == K_LAST) w_next = S_DONE;
         end
         S_DONE: begin
            w_done0 = ~r_gnt;
            w_done1 = r_gnt;
            w_next  = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_k        <= '0;
         r_wcnt     <= '0;
         r_gnt      <= 1'b0;
         r_last_gnt <= 1'b1;
         r_we       <= 1'b0;
         r_rdata0   <= '0;
         r_rdata1   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_gnt  <= w_pick;
                  r_we   <= w_pick_we;
                  r_k    <= '0;
                  r_wcnt <= '0;
                  if (w_both) r_last_gnt <= w_pick;
               end
            end
            S_WAIT: begin
               r_wcnt <= r_wcnt + 1'b1;
            end
            S_RD, S_WR: begin
               r_k <= r_k + 1'b1;
            end
            S_RD_LAST: begin
               if (r_gnt) r_rdata1 <= w_line_in;
               else       r_rdata0 <= w_line_in;
            end
            default: begin
            end
         endcase
      end
   end

   // Read data trails the address by one cycle, so word k-1 lands while word k is addressed.
   always_ff @(posedge clk) begin
      if (r_state == S_IDLE && w_any) begin
         r_line  <= w_pick_line;
         r_wdata <= w_pick_wdata;
      end
      if (r_state == S_RD && r_k != '0) begin
         r_buf[r_k - 1'b1] <= i_mem_rd_data;
      end
   end

   assign o_r0_rdata    = r_rdata0;
   assign o_r1_rdata    = r_rdata1;
   assign o_r0_done     = w_done0;
   assign o_r1_done     = w_done1;
   assign o_mem_addr    = w_mem_addr;
   assign o_mem_wr_req  = w_mem_wr_req;
   assign o_mem_wr_data = w_mem_wr_data;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Scoreboard bench for mem_line_arbiter: one instance without and one with start latency,
// each attached to its own registered single-port memory model.
module tb_mem_line_arbiter;

   typedef struct {
      bit          rid;
      bit          rd;
      logic [255:0] data;
      int          done_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   logic         r0_req [2];
   logic         r0_we [2];
   logic [7:0]   r0_addr [2];
   logic [255:0] r0_wdata [2];
   logic [255:0] r0_rdata [2];
   logic         r0_done [2];
   logic         r1_req [2];
   logic         r1_we [2];
   logic [7:0]   r1_addr [2];
   logic [255:0] r1_wdata [2];
   logic [255:0] r1_rdata [2];
   logic         r1_done [2];
   logic [10:0]  mem_addr [2];
   logic         mem_wr_req [2];
   logic [31:0]  mem_wr_data [2];
   logic [31:0]  mem_rd_data [2];

   logic [31:0]  mem0 [2048];
   logic [31:0]  mem1 [2048];

   exp_t         q0[$];
   exp_t         q1[$];
   logic [255:0] mdl [2][2];
   int           wr_log[$];
   int           rd_log[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (mem_wr_req[0]) mem0[mem_addr[0]] <= mem_wr_data[0];
      mem_rd_data[0] <= mem0[mem_addr[0]];
   end

   always @(posedge clk) begin
      if (mem_wr_req[1]) mem1[mem_addr[1]] <= mem_wr_data[1];
      mem_rd_data[1] <= mem1[mem_addr[1]];
   end

   mem_line_arbiter #(.ADDR_LEN(11), .LINE_WORDS_LOG(3), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst(rst),
      .i_r0_req(r0_req[0]), .i_r0_we(r0_we[0]), .i_r0_addr(r0_addr[0]), .i_r0_wdata(r0_wdata[0]),
      .o_r0_rdata(r0_rdata[0]), .o_r0_done(r0_done[0]),
      .i_r1_req(r1_req[0]), .i_r1_we(r1_we[0]), .i_r1_addr(r1_addr[0]), .i_r1_wdata(r1_wdata[0]),
      .o_r1_rdata(r1_rdata[0]), .o_r1_done(r1_done[0]),
      .o_mem_addr(mem_addr[0]), .o_mem_wr_req(mem_wr_req[0]), .o_mem_wr_data(mem_wr_data[0]),
      .i_mem_rd_data(mem_rd_data[0])
   );

   mem_line_arbiter #(.ADDR_LEN(11), .LINE_WORDS_LOG(3), .WAIT_CYCLES(3)) u_dut1 (
      .clk(clk), .rst(rst),
      .i_r0_req(r0_req[1]), .i_r0_we(r0_we[1]), .i_r0_addr(r0_addr[1]), .i_r0_wdata(r0_wdata[1]),
      .o_r0_rdata(r0_rdata[1]), .o_r0_done(r0_done[1]),
      .i_r1_req(r1_req[1]), .i_r1_we(r1_we[1]), .i_r1_addr(r1_addr[1]), .i_r1_wdata(r1_wdata[1]),
      .o_r1_rdata(r1_rdata[1]), .o_r1_done(r1_done[1]),
      .o_mem_addr(mem_addr[1]), .o_mem_wr_req(mem_wr_req[1]), .o_mem_wr_data(mem_wr_data[1]),
      .i_mem_rd_data(mem_rd_data[1])
   );

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] pat(input int line, input int k);
      return 32'h1000_0000 + 32'(line * 256) + 32'(k);
   endfunction

   function automatic logic [255:0] gen(input int line);
      logic [255:0] v;
      for (int k = 0; k < 8; k++) v[32*k +: 32] = pat(line, k);
      return v;
   endfunction

   task automatic on_done(input int d);
      exp_t e;
      bit   have;
      have = 1'b0;
      chk("both_done", {255'd0, r0_done[d] & r1_done[d]}, 256'd0);
      if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      if (!have) begin
         n_checks++;
         n_errors++;
         $display("FAIL unexpected_done: dut %0d r0_done %0d r1_done %0d at cycle %0d, none expected",
                  d, r0_done[d], r1_done[d], cyc);
      end else begin
         chk("done_rid", {255'd0, r1_done[d]}, {255'd0, e.rid});
         chk("done_cycle", 256'(cyc), 256'(e.done_cyc));
         if (e.rd) mdl[d][e.rid] = e.data;
         chk("r0_rdata", r0_rdata[d], mdl[d][0]);
         chk("r1_rdata", r1_rdata[d], mdl[d][1]);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         for (int d = 0; d < 2; d++) begin
            mdl[d][0] = '0;
            mdl[d][1] = '0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (r0_done[d] || r1_done[d]) on_done(d);
         end
         if (mem_wr_req[0]) wr_log.push_back(int'(mem_addr[0]));
         else if (mem_addr[0] != 11'd0) rd_log.push_back(int'(mem_addr[0]));
      end
   end

   task automatic raise(input int d, input bit rid, input bit we, input logic [7:0] line,
                        input logic [255:0] wd);
      if (!rid) begin
         r0_req[d] = 1'b1; r0_we[d] = we; r0_addr[d] = line; r0_wdata[d] = wd;
      end else begin
         r1_req[d] = 1'b1; r1_we[d] = we; r1_addr[d] = line; r1_wdata[d] = wd;
      end
   endtask

   task automatic push(input int d, input bit rid, input bit rd, input logic [255:0] data,
                       input int dc);
      exp_t e;
      e.rid = rid; e.rd = rd; e.data = data; e.done_cyc = dc;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic wait_idle(input int d, input string name);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (r0_done[d]) r0_req[d] = 1'b0;
         if (r1_done[d]) r1_req[d] = 1'b0;
         if (!r0_req[d] && !r1_req[d]) return;
      end
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: requests still pending after 200 cycles, expected done", name);
      r0_req[d] = 1'b0;
      r1_req[d] = 1'b0;
   endtask

   initial begin
      int           t;
      logic [255:0] t1_line, wa_line, wb_line, mix_line;
      logic [31:0]  t1w [8];
      t1w = '{32'h9d, 32'h87, 32'h83, 32'h3a, 32'h11, 32'h22, 32'h33, 32'hff};
      for (int k = 0; k < 8; k++) begin
         t1_line[32*k +: 32]  = t1w[k];
         wa_line[32*k +: 32]  = 32'hA000_0000 + 32'(k);
         wb_line[32*k +: 32]  = 32'hB000_0000 + 32'(k * 17);
         mix_line[32*k +: 32] = (k < 4) ? 32'h5555_5555 : pat(1, k);
      end
      for (int a = 0; a < 2048; a++) begin
         mem0[a] = pat(a / 8, a % 8);
         mem1[a] = pat(a / 8, a % 8);
      end
      for (int k = 0; k < 8; k++) mem0[k] = t1w[k];
      for (int d = 0; d < 2; d++) begin
         r0_req[d] = 1'b0; r0_we[d] = 1'b0; r0_addr[d] = '0; r0_wdata[d] = '0;
         r1_req[d] = 1'b0; r1_we[d] = 1'b0; r1_addr[d] = '0; r1_wdata[d] = '0;
      end
      rst = 1'b0;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("reset_mem_addr", 256'(mem_addr[d]), 256'd0);
         chk("reset_mem_wr_req", 256'(mem_wr_req[d]), 256'd0);
         chk("reset_mem_wr_data", 256'(mem_wr_data[d]), 256'd0);
         chk("reset_r0_rdata", r0_rdata[d], 256'd0);
         chk("reset_r1_rdata", r1_rdata[d], 256'd0);
         chk("reset_done", 256'({r0_done[d], r1_done[d]}), 256'd0);
      end
      rst = 1'b0;

      // Tie right after reset goes to r0, the next tie to r1.
      @(negedge clk);
      t = cyc;
      raise(0, 1'b0, 1'b0, 8'd4, '0);
      raise(0, 1'b1, 1'b0, 8'd5, '0);
      push(0, 1'b0, 1'b1, gen(4), t + 10);
      push(0, 1'b1, 1'b1, gen(5), t + 21);
      wait_idle(0, "tie1");
      @(negedge clk);
      t = cyc;
      raise(0, 1'b0, 1'b0, 8'd6, '0);
      raise(0, 1'b1, 1'b0, 8'd7, '0);
      push(0, 1'b1, 1'b1, gen(7), t + 10);
      push(0, 1'b0, 1'b1, gen(6), t + 21);
      wait_idle(0, "tie2");

      // r0 refill of line 0 with hand-written contents.
      @(negedge clk);
      wr_log.delete();
      t = cyc;
      raise(0, 1'b0, 1'b0, 8'd0, '0);
      push(0, 1'b0, 1'b1, t1_line, t + 10);
      wait_idle(0, "read_line0");
      chk("t1_word0", 256'(r0_rdata[0][31:0]), 256'h9d);
      chk("t1_word3", 256'(r0_rdata[0][127:96]), 256'h3a);
      chk("t1_word7", 256'(r0_rdata[0][255:224]), 256'hff);
      chk("t1_no_write", 256'(wr_log.size()), 256'd0);

      // r1 write-back of line 2, then r0 refill of it.
      @(negedge clk);
      wr_log.delete();
      t = cyc;
      raise(0, 1'b1, 1'b1, 8'd2, wa_line);
      push(0, 1'b1, 1'b0, '0, t + 9);
      wait_idle(0, "write_line2");
      chk("t2_write_count", 256'(wr_log.size()), 256'd8);
      for (int k = 0; k < 8 && k < wr_log.size(); k++) chk("t2_write_addr", 256'(wr_log[k]), 256'(16 + k));
      @(negedge clk);
      t = cyc;
      raise(0, 1'b0, 1'b0, 8'd2, '0);
      push(0, 1'b0, 1'b1, wa_line, t + 10);
      wait_idle(0, "read_line2");

      // Last line of the address space.
      @(negedge clk);
      rd_log.delete();
      t = cyc;
      raise(0, 1'b1, 1'b0, 8'd255, '0);
      push(0, 1'b1, 1'b1, gen(255), t + 10);
      wait_idle(0, "read_line255");
      chk("t6_read_count", 256'(rd_log.size()), 256'd8);
      for (int k = 0; k < 8 && k < rd_log.size(); k++) chk("t6_read_addr", 256'(rd_log[k]), 256'(2040 + k));

      // Start latency on the second instance.
      @(negedge clk);
      t = cyc;
      raise(1, 1'b0, 1'b0, 8'd3, '0);
      push(1, 1'b0, 1'b1, gen(3), t + 13);
      for (int j = 1; j <= 3; j++) begin
         @(negedge clk);
         chk("t4_wait_addr", 256'(mem_addr[1]), 256'd0);
      end
      @(negedge clk);
      chk("t4_first_addr", 256'(mem_addr[1]), 256'd24);
      wait_idle(1, "wait_read");
      @(negedge clk);
      t = cyc;
      raise(1, 1'b1, 1'b1, 8'd9, wb_line);
      push(1, 1'b1, 1'b0, '0, t + 12);
      wait_idle(1, "wait_write");
      @(negedge clk);
      t = cyc;
      raise(1, 1'b0, 1'b0, 8'd9, '0);
      push(1, 1'b0, 1'b1, wb_line, t + 13);
      wait_idle(1, "wait_readback");

      // Reset in the middle of a write-back of line 1, at word 4.
      @(negedge clk);
      t = cyc;
      raise(0, 1'b1, 1'b1, 8'd1, {8{32'h5555_5555}});
      repeat (5) @(posedge clk);
      #2;
      chk("t5_pre_wr_req", 256'(mem_wr_req[0]), 256'd1);
      chk("t5_pre_addr", 256'(mem_addr[0]), 256'd12);
      rst = 1'b1;
      r1_req[0] = 1'b0;
      #1;
      chk("t5_abort_wr_req", 256'(mem_wr_req[0]), 256'd0);
      chk("t5_abort_addr", 256'(mem_addr[0]), 256'd0);
      chk("t5_abort_done", 256'(r1_done[0]), 256'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 8; k++) chk("t5_mem_word", 256'(mem0[8 + k]), 256'(mix_line[32*k +: 32]));
      @(negedge clk);
      t = cyc;
      raise(0, 1'b1, 1'b0, 8'd1, '0);
      push(0, 1'b1, 1'b1, mix_line, t + 10);
      wait_idle(0, "read_mixed");

      repeat (4) @(negedge clk);
      chk("q0_drained", 256'(q0.size()), 256'd0);
      chk("q1_drained", 256'(q1.size()), 256'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
